i2s_rx_fifo_master: RTL
=======================

Name: i2s_rx_fifo_master

Overview:
Parametrised I2S bus-master receiver that generates BCLK and LRCLK and deserialises the serial data line. It supports standard I2S (one-bit delay) and left-justified framing, selectable at runtime. Both channels are captured with a channel tag. Captured words go into a FIFO and are delivered to the audio datapath over a valid/ready interface, with overflow detection. It replaces the fixed-framing, flag-pulse receiver in the audio front-end.

Parameters:
CLK_DIV, 8, clk_i cycles per BCLK period; even, >= 6.
WORD_LEN, 24, captured bits per channel word.
SLOT_LEN, 32, BCLK periods per channel slot (frame = 2*SLOT_LEN); must be >= WORD_LEN+1.
FIFO_DEPTH, 4, entries; power of two, >= 2.

Ports:
clk_i  in  1  system clock (single clock domain)
rst_ni  in  1  asynchronous, active-low reset
enable_i  in  1  run clocks and capture
mode_i  in  1  0 = I2S (1-bit delay), 1 = left-justified
sd_i  in  1  serial data from codec (asynchronous)
bclk_o  out  1  bit clock
lrclk_o  out  1  word select; 0 = left, 1 = right
sample_o  out  WORD_LEN  FIFO head sample, MSB-first capture
channel_o  out  1  FIFO head channel tag (0 = L, 1 = R)
valid_o  out  1  FIFO not empty
ready_i  in  1  consumer accepts head
fifo_level_o  out  $clog2(FIFO_DEPTH)+1  occupied entries
overflow_o  out  1  sticky: a word was dropped
clear_ovf_i  in  1  clears overflow_o

Behaviour:
- Reset (async, rst_ni low):
  - All outputs are 0: bclk_o, lrclk_o, sample_o, channel_o, valid_o, fifo_level_o, overflow_o.
  - Divider, bit counter, shift register and FIFO pointers are cleared.
- Clock generation:
  - Divider counts 0..CLK_DIV/2-1. At the terminal count bclk_o toggles and the divider wraps.
  - The first rising edge of bclk_o occurs CLK_DIV/2 cycles after enable_i goes high.
- Bit and slot counting:
  - Bit counter b (0..SLOT_LEN-1) advances on each bclk_o falling toggle.
  - On wrap SLOT_LEN-1 -> 0, lrclk_o toggles in the same cycle, so LRCLK changes on a BCLK falling edge.
  - b = 0 means the first BCLK period of the slot.
- Input sampling:
  - sd_i passes through a 2-flop synchroniser.
  - The synchronised bit is captured in the cycle of each bclk_o rising toggle. This is half a BCLK period after the transmitter launch, less 2 cycles of synchroniser latency.
- Bit positions per mode:
  - mode_i = 0 (I2S): captures at b = 1..WORD_LEN.
  - mode_i = 1 (LJ): captures at b = 0..WORD_LEN-1.
  - MSB first, shifted in from the LSB side. Bits outside these positions are ignored.
- mode_i is latched at b = 0 of each slot. A change mid-slot takes effect from the next slot.
- Word completion and push:
  - The last bit is captured at edge N. The FIFO write of {lrclk_o of the slot, word} happens at edge N+1.
  - valid_o rises after edge N+1 if the FIFO was empty.
- FIFO and handshake:
  - First-in first-out. sample_o and channel_o always show the head entry.
  - Pop occurs when valid_o && ready_i at a clock edge.
  - Head outputs and valid_o are stable while valid_o && !ready_i.
- Full condition:
  - A push into a full FIFO with no pop in the same cycle drops the new word, sets overflow_o and leaves the contents unchanged.
  - Push and pop in the same cycle while full: both happen, level is unchanged, no overflow.
  - Push and pop in the same cycle while non-empty: level is unchanged.
- Overflow flag: clear_ovf_i clears overflow_o. If a set and a clear occur in the same cycle, the set wins.
- enable_i low:
  - Next edge: divider and b reset, bclk_o = 0, lrclk_o = 0, partial word discarded.
  - FIFO and handshake remain operational and overflow_o is held.
  - Re-enable restarts with the left slot at b = 0.
- fifo_level_o ranges 0..FIFO_DEPTH and updates on the edge of a push or pop.

Optional Feature:
I2S_RX_OVF_CNT_EN: when defined, adds port ovf_count_o (out, 16 bits). It counts dropped words, saturates at 0xFFFF, resets to 0, and is cleared together with overflow_o by clear_ovf_i (increment wins on a simultaneous event). When undefined, the port and counter do not exist and all other behaviour is identical.

Test Plan:
- Reset: hold rst_ni low mid-frame -> all outputs 0 immediately (async); after release and enable_i = 1, first bclk_o rise at cycle 4 and bclk_o period 8 clk_i; lrclk_o period 512 clk_i.
- I2S mode: codec model sends L = 0xA5A5A5, R = 0x5A5A5A, ready_i = 1 -> pops {0,0xA5A5A5} then {1,0x5A5A5A}; valid_o high 1 cycle after capture of the 24th bit.
- Mode mismatch: LJ stream of L = 0xA5A5A5 with mode_i = 0 -> {0,0x4B4B4A}; same stream with mode_i = 1 -> {0,0xA5A5A5}; mode_i toggled mid-slot affects only the next slot.
- Overflow: ready_i = 0, 5 words arrive -> fifo_level_o = 4, 5th dropped, overflow_o = 1; then ready_i = 1 -> first 4 words drained in order; clear_ovf_i pulse -> overflow_o = 0 (ovf_count_o = 1 if I2S_RX_OVF_CNT_EN).
- Full and simultaneous: FIFO full, ready_i = 1 in the push cycle -> no overflow, level stays 4; clear_ovf_i in the same cycle as a drop -> overflow_o stays 1.
- Enable drop: enable_i = 0 at b = 10 of the right slot -> bclk_o and lrclk_o 0 next cycle, no partial push, FIFO contents intact; re-enable -> next word is tagged channel 0.

Source files
------------

// File: rtl/i2s_rx_fifo_master.sv
// rtl/i2s_rx_fifo_master.sv - I2S bus-master receiver (I2S / left-justified) with FIFO and valid/ready output
// Optional: define I2S_RX_OVF_CNT_EN to add the 16-bit saturating dropped-word counter ovf_count_o.
module i2s_rx_fifo_master #(
   parameter int CLK_DIV    = 8,
   parameter int WORD_LEN   = 24,
   parameter int SLOT_LEN   = 32,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                          clk_i,
   input  logic                          rst_ni,
   input  logic                          enable_i,
   input  logic                          mode_i,
   input  logic                          sd_i,
   output logic                          bclk_o,
   output logic                          lrclk_o,
   output logic [WORD_LEN-1:0]           sample_o,
   output logic                          channel_o,
   output logic                          valid_o,
   input  logic                          ready_i,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_level_o,
   output logic                          overflow_o,
   input  logic                          clear_ovf_i
`ifdef I2S_RX_OVF_CNT_EN
   ,
   output logic [15:0]                   ovf_count_o
`endif
);

   localparam int HALF = CLK_DIV / 2;
   localparam int DW   = $clog2(HALF);
   localparam int BW   = $clog2(SLOT_LEN);
   localparam int AW   = $clog2(FIFO_DEPTH);

   localparam logic [DW-1:0] DIV_LAST  = DW'(HALF - 1);
   localparam logic [DW-1:0] DIV_ONE   = DW'(1);
   localparam logic [BW-1:0] BIT_LAST  = BW'(SLOT_LEN - 1);
   localparam logic [BW-1:0] BIT_ONE   = BW'(1);
   localparam logic [BW-1:0] BIT_WORD  = BW'(WORD_LEN);
   localparam logic [BW-1:0] BIT_WORDM = BW'(WORD_LEN - 1);
   localparam logic [AW:0]   PTR_ONE   = (AW+1)'(1);
   localparam logic [AW:0]   LVL_FULL  = (AW+1)'(FIFO_DEPTH);

   logic [DW-1:0]       div_q;
   logic [BW-1:0]       bit_q;
   logic                tick, rise, fall;

   logic                sd_meta, sd_sync;
   logic [WORD_LEN-1:0] shift_q;
   logic                mode_q, mode_eff;
   logic                cap_en, last_bit, push_q;

   logic [WORD_LEN:0]   mem_q [FIFO_DEPTH];
   logic [AW:0]         wr_ptr_q, rd_ptr_q;
   logic                pop, full, push_ok, drop;
   logic [WORD_LEN:0]   head;

   assign tick = enable_i && (div_q == DIV_LAST);
   assign rise = tick && !bclk_o;
   assign fall = tick && bclk_o;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         div_q   <= '0;
         bit_q   <= '0;
         bclk_o  <= 1'b0;
         lrclk_o <= 1'b0;
      end else if (!enable_i) begin
         div_q   <= '0;
         bit_q   <= '0;
         bclk_o  <= 1'b0;
         lrclk_o <= 1'b0;
      end else begin
         if (tick) begin
            div_q  <= '0;
            bclk_o <= ~bclk_o;
         end else begin
            div_q  <= div_q + DIV_ONE;
         end
         // Slot boundary lands on a falling BCLK edge, so LRCLK moves with it.
         if (fall) begin
            if (bit_q == BIT_LAST) begin
               bit_q   <= '0;
               lrclk_o <= ~lrclk_o;
            end else begin
               bit_q   <= bit_q + BIT_ONE;
            end
         end
      end
   end

   // At b = 0 the live mode_i applies; later bits use the value latched at b = 0.
   assign mode_eff = (bit_q == '0) ? mode_i : mode_q;
   assign cap_en   = mode_eff ? (bit_q <= BIT_WORDM)
                              : ((bit_q != '0) && (bit_q <= BIT_WORD));
   assign last_bit = mode_eff ? (bit_q == BIT_WORDM) : (bit_q == BIT_WORD);

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         sd_meta <= 1'b0;
         sd_sync <= 1'b0;
         shift_q <= '0;
         mode_q  <= 1'b0;
         push_q  <= 1'b0;
      end else begin
         sd_meta <= sd_i;
         sd_sync <= sd_meta;
         push_q  <= rise && cap_en && last_bit;
         if (!enable_i) begin
            shift_q <= '0;
            mode_q  <= 1'b0;
         end else if (rise) begin
            if (bit_q == '0) mode_q <= mode_i;
            if (cap_en) shift_q <= {shift_q[WORD_LEN-2:0], sd_sync};
         end
      end
   end

   assign fifo_level_o = wr_ptr_q - rd_ptr_q;
   assign valid_o      = (fifo_level_o != '0);
   assign full         = (fifo_level_o == LVL_FULL);
   assign pop          = valid_o && ready_i;
   assign push_ok      = push_q && (!full || pop);
   assign drop         = push_q && full && !pop;
   assign head         = mem_q[rd_ptr_q[AW-1:0]];
   assign sample_o     = head[WORD_LEN-1:0];
   assign channel_o    = head[WORD_LEN];

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         if (push_ok) begin
            mem_q[wr_ptr_q[AW-1:0]] <= {lrclk_o, shift_q};
            wr_ptr_q <= wr_ptr_q + PTR_ONE;
         end
         if (pop) rd_ptr_q <= rd_ptr_q + PTR_ONE;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         overflow_o <= 1'b0;
      end else if (drop) begin
         overflow_o <= 1'b1;
      end else if (clear_ovf_i) begin
         overflow_o <= 1'b0;
      end
   end

`ifdef I2S_RX_OVF_CNT_EN
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         ovf_count_o <= '0;
      end else if (drop) begin
         if (ovf_count_o != 16'hFFFF) ovf_count_o <= ovf_count_o + 16'd1;
      end else if (clear_ovf_i) begin
         ovf_count_o <= '0;
      end
   end
`endif

endmodule
